// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: bus-programmed duty ramp (one-shot or bounce) feeding a pwm core.
module pwm_fade_sequencer #(
   parameter int CtrSize       = 8,
   parameter int PrescaleWidth = 16,
   parameter int AddrWidth     = 32,
   parameter int DataWidth     = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 device_req_i,
   input  logic [AddrWidth-1:0] device_addr_i,
   input  logic                 device_we_i,
   input  logic [3:0]           device_be_i,
   input  logic [DataWidth-1:0] device_wdata_i,
   output logic                 device_rvalid_o,
   output logic [DataWidth-1:0] device_rdata_o,
   output logic [CtrSize-1:0]   pulse_width_o,
   output logic [CtrSize-1:0]   max_counter_o,
   output logic                 done_o
);
   typedef enum logic [1:0] {Idle, Up, Down, Done} state_e;
   state_e state;
   logic en, bounce, wr, tick, unused;
   logic [2:0] sel;
   logic [CtrSize-1:0] lim_min, lim_max, period, duty;
   logic [PrescaleWidth-1:0] step, cnt;
   logic [DataWidth-1:0] status, rd_mux;
   assign wr = device_req_i & device_we_i;
   assign sel = device_addr_i[4:2];
   assign tick = cnt == step;
   assign pulse_width_o = duty;
   assign max_counter_o = period;
   assign done_o = state == Done;
   assign unused = ^{device_be_i, device_addr_i, device_wdata_i};
   always_comb begin
      status = '0;
      status[CtrSize-1:0] = duty;
      status[16] = state == Down;
      status[17] = state == Done;
   end
   always_comb begin
      rd_mux = '0;
      case (sel)
         3'd0: rd_mux[1:0] = {bounce, en};
         3'd1: rd_mux[2*CtrSize-1:0] = {lim_max, lim_min};
         3'd2: rd_mux[PrescaleWidth-1:0] = step;
         3'd3: rd_mux = status;
         3'd4: rd_mux[CtrSize-1:0] = period;
         default: rd_mux = '0;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         device_rvalid_o <= 1'b0;
         device_rdata_o <= '0;
         en <= 1'b0;
         bounce <= 1'b0;
         lim_min <= '0;
         lim_max <= '0;
         step <= '0;
         period <= '0;
         cnt <= '0;
         duty <= '0;
         state <= Idle;
      end else begin
         device_rvalid_o <= device_req_i;
         device_rdata_o <= (device_req_i & ~device_we_i) ? rd_mux : '0;
         if (wr) begin
            case (sel)
               3'd0: {bounce, en} <= device_wdata_i[1:0];
               3'd1: {lim_max, lim_min} <= device_wdata_i[2*CtrSize-1:0];
               3'd2: step <= device_wdata_i[PrescaleWidth-1:0];
               3'd4: period <= device_wdata_i[CtrSize-1:0];
               default: ;
            endcase
         end
         // restart the step interval whenever a ramp starts or the interval changes
         cnt <= ((wr && sel == 3'd2) || (state == Idle && en) || tick) ? '0 : cnt + 1'b1;
         if (!en) begin
            state <= Idle;
            duty <= lim_min;
         end else begin
            case (state)
               Idle: begin
                  state <= Up;
                  duty <= lim_min;
               end
               Up: if (tick) begin
                  if (duty < lim_max) duty <= duty + 1'b1;
                  else state <= bounce ? Down : Done;
               end
               Down: if (tick) begin
                  if (duty > lim_min) duty <= duty - 1'b1;
                  else state <= Up;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb_pwm_fade_sequencer: directed and random bus traffic against a behavioural fade model.
module tb_pwm_fade_sequencer;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0] be = 4'hf;
   logic rvalid, done;
   logic [31:0] rdata;
   logic [7:0] pw, mc;
   int n_cmp = 0, n_bad = 0;
   // model: ph 0 parked, 1 rising, 2 falling, 3 finished
   int m_en = 0, m_bnc = 0, m_min = 0, m_max = 0, m_step = 0, m_period = 0;
   int m_duty = 0, m_ph = 0, m_el = 0, m_rvalid = 0, m_rdata = 0;
   int n_duty, n_ph, n_el;
   bit t_tick;

   pwm_fade_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .device_req_i(req), .device_addr_i(addr),
      .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
      .device_rvalid_o(rvalid), .device_rdata_o(rdata),
      .pulse_width_o(pw), .max_counter_o(mc), .done_o(done)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int mread(input int r);
      case (r)
         0: return m_bnc * 2 + m_en;
         1: return m_max * 256 + m_min;
         2: return m_step;
         3: return m_duty + ((m_ph == 2) ? 32'h1_0000 : 0) + ((m_ph == 3) ? 32'h2_0000 : 0);
         4: return m_period;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_en = 0; m_bnc = 0; m_min = 0; m_max = 0; m_step = 0; m_period = 0;
         m_duty = 0; m_ph = 0; m_el = 0; m_rvalid = 0; m_rdata = 0;
      end else begin
         t_tick = (m_el % (m_step + 1)) == m_step;
         n_duty = m_duty; n_ph = m_ph; n_el = m_el + 1;
         if (m_en == 0) begin n_ph = 0; n_duty = m_min; end
         else if (m_ph == 0) begin n_ph = 1; n_duty = m_min; n_el = 0; end
         else if (m_ph == 1 && t_tick) begin
            if (m_duty < m_max) n_duty = m_duty + 1; else n_ph = m_bnc ? 2 : 3;
         end else if (m_ph == 2 && t_tick) begin
            if (m_duty > m_min) n_duty = m_duty - 1; else n_ph = 1;
         end
         m_rvalid = int'(req);
         m_rdata = (req && !we) ? mread(int'(addr[4:2])) : 0;
         if (req && we) begin
            case (addr[4:2])
               3'd0: begin m_en = int'(wdata[0]); m_bnc = int'(wdata[1]); end
               3'd1: begin m_min = int'(wdata[7:0]); m_max = int'(wdata[15:8]); end
               3'd2: begin m_step = int'(wdata[15:0]); n_el = 0; end
               3'd4: m_period = int'(wdata[7:0]);
               default: ;
            endcase
         end
         m_duty = n_duty; m_ph = n_ph; m_el = n_el;
      end
   end

   always @(negedge clk_i) begin
      chk("pulse_width", {24'b0, pw}, m_duty);
      chk("max_counter", {24'b0, mc}, m_period);
      chk("done", {31'b0, done}, m_ph == 3);
      chk("rvalid", {31'b0, rvalid}, m_rvalid);
      chk("rdata", rdata, m_rdata);
   end

   task automatic wr(input int r, input logic [31:0] d, input logic [3:0] b = 4'hf);
      req = 1'b1; we = 1'b1; addr = r * 4; wdata = d; be = b;
      @(negedge clk_i);
      req = 1'b0; we = 1'b0; be = 4'hf;
   endtask

   task automatic rd(input int r, output logic [31:0] d);
      req = 1'b1; we = 1'b0; addr = r * 4;
      @(negedge clk_i);
      req = 1'b0;
      d = rdata;
      chk("rd_rvalid", {31'b0, rvalid}, 1);
   endtask

   initial begin
      logic [31:0] d, a;
      int n, r;
      int seq[11] = '{0, 0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
      repeat (3) @(negedge clk_i);
      chk("reset_pw", {24'b0, pw}, 0);
      chk("reset_rvalid", {31'b0, rvalid}, 0);
      chk("reset_done", {31'b0, done}, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      rd(3, d);
      chk("reset_status", d, 0);
      @(negedge clk_i);
      chk("rvalid_one_cycle", {31'b0, rvalid}, 0);
      // one-shot ramp 0x10..0x14 at one step per two cycles
      wr(4, 32'hff); wr(1, 32'h1410); wr(2, 1); wr(0, 1);
      n = 0;
      while (!done && n < 50) begin @(negedge clk_i); n++; end
      chk("oneshot_cycles", n, 11);
      chk("oneshot_pw", {24'b0, pw}, 32'h14);
      chk("oneshot_mc", {24'b0, mc}, 32'hff);
      rd(3, d);
      chk("oneshot_status", d, 32'h0002_0014);
      // bounce between 0 and 3 every cycle
      wr(0, 0); wr(1, 32'h0300); wr(2, 0); wr(0, 3);
      for (int i = 0; i < 11; i++) begin
         chk("bounce_seq", {24'b0, pw}, seq[i]);
         @(negedge clk_i);
      end
      n = 0; d = 0;
      while (!d[16] && n < 20) begin rd(3, d); n++; end
      chk("bounce_dir_seen", {31'b0, d[16]}, 1);
      // disable mid-ramp
      wr(0, 0); wr(1, 32'h1410); wr(2, 3); wr(0, 1);
      n = 0;
      while (pw != 8'h12 && n < 60) begin @(negedge clk_i); n++; end
      chk("midramp_reached", {24'b0, pw}, 32'h12);
      wr(0, 0);
      @(negedge clk_i);
      chk("disable_pw", {24'b0, pw}, 32'h10);
      chk("disable_done", {31'b0, done}, 0);
      // inverted limits
      wr(1, 32'h0205); wr(2, 0); wr(0, 1);
      repeat (4) @(negedge clk_i);
      chk("inverted_pw", {24'b0, pw}, 5);
      chk("inverted_done", {31'b0, done}, 1);
      // back-to-back bus traffic
      wr(2, 7);
      rd(2, d);
      chk("step_rb", d, 7);
      rd(6, d);
      chk("unmapped_rd", d, 0);
      wr(2, 32'h1234, 4'h1);
      rd(2, d);
      chk("be_full_word", d, 32'h1234);
      wr(2, 1);
      // random traffic, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 7);
            a = $urandom();
            a[4:2] = 3'(r);
            d = $urandom();
            if (r == 0) d[0] = ($urandom_range(0, 7) != 0);
            if (r == 1) begin d[7:0] = 8'($urandom_range(0, 24)); d[15:8] = 8'($urandom_range(0, 24)); end
            if (r == 2) d[15:0] = 16'($urandom_range(0, 3));
            req = 1'b1; we = 1'($urandom_range(0, 1)); addr = a; wdata = d;
            be = 4'($urandom_range(0, 15));
            @(negedge clk_i);
            req = 1'b0; we = 1'b0;
         end else @(negedge clk_i);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
